// File: rtl/quad_bbox_setup_if.sv
// Quad setup bus: upstream vertex handshake plus downstream screen-space result handshake.
interface quad_bbox_setup_if;
    localparam int unsigned CW = 21;
    localparam int unsigned SW = 23;
    localparam int unsigned BW = 12;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [CW-1:0] vtx_x [4];
    logic signed [CW-1:0] vtx_y [4];
    logic signed [CW-1:0] vtx_z [4];

    logic                 out_valid;
    logic                 out_ready;
    logic signed [SW-1:0] sx [4];
    logic signed [SW-1:0] sy [4];
    logic signed [CW-1:0] sz [4];
    logic [BW-1:0]        bb_xmin;
    logic [BW-1:0]        bb_xmax;
    logic [BW-1:0]        bb_ymin;
    logic [BW-1:0]        bb_ymax;
    logic                 culled;

    modport master (
        output in_valid, vtx_x, vtx_y, vtx_z, out_ready,
        input  in_ready, out_valid, sx, sy, sz,
        input  bb_xmin, bb_xmax, bb_ymin, bb_ymax, culled
    );

    modport slave (
        input  in_valid, vtx_x, vtx_y, vtx_z, out_ready,
        output in_ready, out_valid, sx, sy, sz,
        output bb_xmin, bb_xmax, bb_ymin, bb_ymax, culled
    );
endinterface

// File: rtl/quad_bbox_setup.sv
// Rasterizer setup: centre-relative vertices to top-left screen space, clamped bbox and cull flag.
module quad_bbox_setup #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int FRAC_BITS = 0
) (
    input  logic             clk,
    input  logic             rst,
    quad_bbox_setup_if.slave bus
);
    localparam int unsigned CW = 21;
    localparam int unsigned SW = 23;
    localparam int unsigned BW = 12;

    localparam logic signed [SW-1:0] HALF_H = SW'(H_RES / 2);
    localparam logic signed [SW-1:0] HALF_V = SW'(V_RES / 2);
    localparam logic signed [SW-1:0] XMAX   = SW'(H_RES - 1);
    localparam logic signed [SW-1:0] YMAX   = SW'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

    state_t               state_q, state_d;
    logic [1:0]           k_q, k_d;

    logic signed [CW-1:0] vx_q [4];
    logic signed [CW-1:0] vy_q [4];
    logic signed [CW-1:0] sz_q [4];
    logic signed [SW-1:0] sx_q [4];
    logic signed [SW-1:0] sy_q [4];
    logic signed [SW-1:0] minx_q, maxx_q, miny_q, maxy_q;
    logic [BW-1:0]        bb_xmin_q, bb_xmax_q, bb_ymin_q, bb_ymax_q;
    logic                 culled_q;

    logic                 accept;
    logic signed [SW-1:0] ext_x, ext_y, cur_sx, cur_sy;
    logic signed [SW-1:0] minx_c, maxx_c, miny_c, maxy_c;
    logic                 first, cull_c;

    assign accept = (state_q == IDLE) && bus.in_valid;

    // Current vertex transform; sign-extend before the floor shift so nothing can overflow
    always_comb begin
        ext_x  = {{(SW-CW){vx_q[k_q][CW-1]}}, vx_q[k_q]};
        ext_y  = {{(SW-CW){vy_q[k_q][CW-1]}}, vy_q[k_q]};
        cur_sx = (ext_x >>> FRAC_BITS) + HALF_H;
        cur_sy = HALF_V - (ext_y >>> FRAC_BITS);
    end

    // Running extents including the current vertex; vertex1 seeds them
    always_comb begin
        first  = (k_q == 2'd0);
        minx_c = (first || cur_sx < minx_q) ? cur_sx : minx_q;
        maxx_c = (first || cur_sx > maxx_q) ? cur_sx : maxx_q;
        miny_c = (first || cur_sy < miny_q) ? cur_sy : miny_q;
        maxy_c = (first || cur_sy > maxy_q) ? cur_sy : maxy_q;
        cull_c = maxx_c[SW-1] || (minx_c > XMAX) || maxy_c[SW-1] || (miny_c > YMAX);
    end

    // State and vertex counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = SCAN;
                    k_d     = 2'd0;
                end
            end
            SCAN: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = OUT;
            end
            OUT: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Input capture, per-vertex results, extents and final clamp/cull
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                vx_q[i] <= '0;
                vy_q[i] <= '0;
                sz_q[i] <= '0;
                sx_q[i] <= '0;
                sy_q[i] <= '0;
            end
            minx_q    <= '0;
            maxx_q    <= '0;
            miny_q    <= '0;
            maxy_q    <= '0;
            bb_xmin_q <= '0;
            bb_xmax_q <= '0;
            bb_ymin_q <= '0;
            bb_ymax_q <= '0;
            culled_q  <= 1'b0;
        end else begin
            if (accept) begin
                vx_q <= bus.vtx_x;
                vy_q <= bus.vtx_y;
                sz_q <= bus.vtx_z;
            end
            if (state_q == SCAN) begin
                sx_q[k_q] <= cur_sx;
                sy_q[k_q] <= cur_sy;
                minx_q    <= minx_c;
                maxx_q    <= maxx_c;
                miny_q    <= miny_c;
                maxy_q    <= maxy_c;
                if (k_q == 2'd3) begin
                    culled_q <= cull_c;
                    if (cull_c) begin
                        bb_xmin_q <= '0;
                        bb_xmax_q <= '0;
                        bb_ymin_q <= '0;
                        bb_ymax_q <= '0;
                    end else begin
                        bb_xmin_q <= minx_c[SW-1] ? '0 : minx_c[BW-1:0];
                        bb_xmax_q <= (maxx_c > XMAX) ? XMAX[BW-1:0] : maxx_c[BW-1:0];
                        bb_ymin_q <= miny_c[SW-1] ? '0 : miny_c[BW-1:0];
                        bb_ymax_q <= (maxy_c > YMAX) ? YMAX[BW-1:0] : maxy_c[BW-1:0];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.sx        = sx_q;
    assign bus.sy        = sy_q;
    assign bus.sz        = sz_q;
    assign bus.bb_xmin   = bb_xmin_q;
    assign bus.bb_xmax   = bb_xmax_q;
    assign bus.bb_ymin   = bb_ymin_q;
    assign bus.bb_ymax   = bb_ymax_q;
    assign bus.culled    = culled_q;
endmodule

// File: tb/tb_quad_bbox_setup.sv
// Directed bench for quad_bbox_setup: default instance plus a FRAC_BITS=10 instance on shared inputs.
module tb_quad_bbox_setup;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    quad_bbox_setup_if bus0 ();
    quad_bbox_setup_if bus1 ();

    quad_bbox_setup dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    quad_bbox_setup #(.H_RES(640), .V_RES(480), .FRAC_BITS(10))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.out_ready = bus0.out_ready;
    assign bus1.vtx_x     = bus0.vtx_x;
    assign bus1.vtx_y     = bus0.vtx_y;
    assign bus1.vtx_z     = bus0.vtx_z;

    int checks   = 0;
    int failures = 0;
    int lat;
    int seen;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int zb, input int x0, input int x1, input int x2, input int x3,
                        input int y0, input int y1, input int y2, input int y3);
        bus0.vtx_x[0] = 21'(x0); bus0.vtx_x[1] = 21'(x1);
        bus0.vtx_x[2] = 21'(x2); bus0.vtx_x[3] = 21'(x3);
        bus0.vtx_y[0] = 21'(y0); bus0.vtx_y[1] = 21'(y1);
        bus0.vtx_y[2] = 21'(y2); bus0.vtx_y[3] = 21'(y3);
        for (int i = 0; i < 4; i++) bus0.vtx_z[i] = 21'(zb + i);
    endtask

    // Caller is at a negedge with the DUT idle; returns just after the accept edge
    task automatic accept_quad();
        bus0.in_valid = 1'b1;
        @(posedge clk);
        #1 bus0.in_valid = 1'b0;
    endtask

    // Edges after the accept edge until out_valid is seen at a negedge; -1 on timeout
    task automatic wait_out(output int n);
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus0.out_valid) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic handshake(input string tag);
        bus0.out_ready = 1'b1;
        @(posedge clk);
        #1 bus0.out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_ov_low"}, longint'(bus0.out_valid), 0);
        check({tag, "_ir_high"}, longint'(bus0.in_ready), 1);
    endtask

    task automatic check_quad(input string tag, input int zb,
                              input int sx0, input int sx1, input int sx2, input int sx3,
                              input int sy0, input int sy1, input int sy2, input int sy3,
                              input int bx0, input int bx1, input int by0, input int by1,
                              input int cul);
        int esx [4];
        int esy [4];
        esx = '{sx0, sx1, sx2, sx3};
        esy = '{sy0, sy1, sy2, sy3};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_sx%0d", tag, i + 1), longint'(bus0.sx[i]), longint'(esx[i]));
            check($sformatf("%s_sy%0d", tag, i + 1), longint'(bus0.sy[i]), longint'(esy[i]));
            check($sformatf("%s_sz%0d", tag, i + 1), longint'(bus0.sz[i]), longint'(zb + i));
        end
        check({tag, "_bb_xmin"}, longint'(bus0.bb_xmin), longint'(bx0));
        check({tag, "_bb_xmax"}, longint'(bus0.bb_xmax), longint'(bx1));
        check({tag, "_bb_ymin"}, longint'(bus0.bb_ymin), longint'(by0));
        check({tag, "_bb_ymax"}, longint'(bus0.bb_ymax), longint'(by1));
        check({tag, "_culled"}, longint'(bus0.culled), longint'(cul));
    endtask

    initial begin
        // Reset with in_valid held high: must be ignored
        rst            = 1'b1;
        bus0.in_valid  = 1'b1;
        bus0.out_ready = 1'b0;
        load(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", longint'(bus0.in_ready), 1);
        check("rst_out_valid", longint'(bus0.out_valid), 0);
        check("rst_culled", longint'(bus0.culled), 0);
        check("rst_bb_xmax", longint'(bus0.bb_xmax), 0);
        check("rst_sx1", longint'(bus0.sx[0]), 0);
        check("rst_sz4", longint'(bus0.sz[3]), 0);
        rst           = 1'b0;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", longint'(bus0.in_ready), 1);

        // Centred quad, out_ready raised early and held
        load(-7, -100, 100, 100, -100, 50, 50, -50, -50);
        bus0.out_ready = 1'b1;
        accept_quad();
        wait_out(lat);
        check("centred_latency", longint'(lat), 4);
        check("centred_in_ready", longint'(bus0.in_ready), 0);
        check_quad("centred", -7, 220, 420, 420, 220, 190, 190, 290, 290, 220, 420, 190, 290, 0);
        handshake("centred");

        // Partial off-screen, accepted back-to-back for 6-cycle throughput
        load(100, -400, 0, 0, -400, 300, 300, 0, 0);
        accept_quad();
        wait_out(lat);
        check("partial_latency", longint'(lat), 4);
        check_quad("partial", 100, -80, 320, 320, -80, -60, -60, 240, 240, 0, 320, 0, 240, 0);
        handshake("partial");

        // Fully off-screen to the right
        load(-300, 400, 400, 400, 400, 0, 0, 0, 0);
        accept_quad();
        wait_out(lat);
        check_quad("offscr", -300, 720, 720, 720, 720, 240, 240, 240, 240, 0, 0, 0, 0, 1);
        handshake("offscr");

        // Exact screen limits on both axes
        load(1, -320, 319, -320, 319, 240, -239, 240, -239);
        accept_quad();
        wait_out(lat);
        check_quad("limits", 1, 0, 639, 0, 639, 0, 479, 0, 479, 0, 639, 0, 479, 0);
        handshake("limits");

        // Degenerate quad one pixel past the right edge
        load(9, 320, 320, 320, 320, 0, 0, 0, 0);
        accept_quad();
        wait_out(lat);
        check_quad("edge640", 9, 640, 640, 640, 640, 240, 240, 240, 240, 0, 0, 0, 0, 1);
        handshake("edge640");

        // Backpressure with a competing second quad on the inputs
        load(5, 10, 20, 30, 40, -5, 5, 15, -15);
        accept_quad();
        wait_out(lat);
        check("bp_latency", longint'(lat), 4);
        load(50, -10, -10, 10, 10, -10, 10, 10, -10);
        bus0.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_ov_%0d", c), longint'(bus0.out_valid), 1);
            check($sformatf("bp_ir_%0d", c), longint'(bus0.in_ready), 0);
            check($sformatf("bp_xmin_%0d", c), longint'(bus0.bb_xmin), 330);
        end
        bus0.in_valid = 1'b0;
        check_quad("bp_a", 5, 330, 340, 350, 360, 245, 235, 225, 255, 330, 360, 225, 255, 0);
        handshake("bp_a");
        accept_quad();
        wait_out(lat);
        check("bp_b_latency", longint'(lat), 4);
        check_quad("bp_b", 50, 310, 310, 330, 330, 250, 230, 230, 250, 310, 330, 230, 250, 0);
        handshake("bp_b");

        // Reset while scanning vertex 2: quad must vanish
        load(77, -100, 100, 100, -100, 50, 50, -50, -50);
        accept_quad();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        bus0.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus0.out_valid) seen++;
        end
        bus0.out_ready = 1'b0;
        check("midrst_no_out_valid", longint'(seen), 0);
        check("midrst_in_ready", longint'(bus0.in_ready), 1);
        check("midrst_bb_xmax", longint'(bus0.bb_xmax), 0);
        accept_quad();
        wait_out(lat);
        check("midrst_latency", longint'(lat), 4);
        check_quad("midrst", 77, 220, 420, 420, 220, 190, 190, 290, 290, 220, 420, 190, 290, 0);
        handshake("midrst");

        // Fractional inputs, checked on the FRAC_BITS=10 instance
        load(0, 'h1FFFFF, 'h000400, 0, 0, 'h000800, 0, 0, 0);
        accept_quad();
        wait_out(lat);
        check("frac_out_valid", longint'(bus1.out_valid), 1);
        check("frac_sx1", longint'(bus1.sx[0]), 319);
        check("frac_sx2", longint'(bus1.sx[1]), 321);
        check("frac_sx3", longint'(bus1.sx[2]), 320);
        check("frac_sy1", longint'(bus1.sy[0]), 238);
        check("frac_sy2", longint'(bus1.sy[1]), 240);
        check("frac_bb_xmin", longint'(bus1.bb_xmin), 319);
        check("frac_bb_xmax", longint'(bus1.bb_xmax), 321);
        check("frac_bb_ymin", longint'(bus1.bb_ymin), 238);
        check("frac_bb_ymax", longint'(bus1.bb_ymax), 240);
        check("frac_culled", longint'(bus1.culled), 0);
        check("frac0_sx1", longint'(bus0.sx[0]), 319);
        check("frac0_sx2", longint'(bus0.sx[1]), 1344);
        handshake("frac");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
